// File: rtl/fp_align_stage.sv
// fp_align_stage: front end of the dual-path FP adder.
// Unpacks two packed operands, applies add/subtract, orders them by
// magnitude and right-aligns the smaller significand with guard, round and
// sticky bits. The aligned pair (SIZE_MANTISSA+3 bits wide) is what the
// far-path datapath consumes; near_path tells the next stage which path to use.
// Two register stages, one operation per cycle, and a single global stall.
//
// Handshake: an operand pair transfers when in_valid && in_ready at a rising
// clock edge; a result transfers when out_valid && out_ready. While
// out_valid=1 and out_ready=0 every output holds its value. in_ready is a
// combinational function of out_valid/out_ready only (it never looks at in_valid).
//
// Optional build macro SPECIAL_CASE_EN: adds special_o / special_res_o, which
// flag operands with an all-ones exponent (Inf/NaN) and give the IEEE result.
module fp_align_stage #(
  parameter int SIZE_MANTISSA = 24,
  parameter int SIZE_EXPONENT = 8,
  parameter int SIZE_COUNTER  = 5,
  parameter int SIZE_WORD     = SIZE_EXPONENT + SIZE_MANTISSA
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE_WORD-1:0]       a_number,
  input  logic [SIZE_WORD-1:0]       b_number,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       eff_op,
  output logic                       near_path,
  output logic                       sign_o,
  output logic [SIZE_MANTISSA+2:0]   m_a_number,
  output logic [SIZE_MANTISSA+2:0]   m_b_number,
  output logic [SIZE_EXPONENT-1:0]   e_a_number,
  output logic [SIZE_EXPONENT-1:0]   e_b_number
`ifdef SPECIAL_CASE_EN
  ,
  output logic                       special_o,
  output logic [SIZE_WORD-1:0]       special_res_o
`endif
);

  localparam int FW = SIZE_MANTISSA - 1;   // stored fraction width
  localparam int MW = SIZE_MANTISSA + 3;   // aligned significand width (with G/R/S)
  localparam logic [SIZE_EXPONENT-1:0] MAX_SHIFT = SIZE_EXPONENT'(SIZE_MANTISSA + 2);
  localparam logic [SIZE_EXPONENT-1:0] ALL_OUT   = SIZE_EXPONENT'(SIZE_MANTISSA + 3);
  localparam logic [SIZE_EXPONENT-1:0] EXP_ONE   = SIZE_EXPONENT'(1);

  // Global pipeline enable: both stages move together.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // ---------------- Stage 1: unpack, effective op, magnitude order ----------
  logic                     sa, sb_eff, hid_a, hid_b, swap;
  logic [SIZE_EXPONENT-1:0] ea_raw, eb_raw, ea_eff, eb_eff;
  logic [SIZE_MANTISSA-1:0] ma, mb;
  logic [SIZE_EXPONENT-1:0] el, es;
  logic [SIZE_MANTISSA-1:0] ml, ms;
  logic                     sign_l;

  // Unpack operands and pick the larger magnitude; exponent 0 aligns as 1.
  always_comb begin
    sa     = a_number[SIZE_WORD-1];
    sb_eff = b_number[SIZE_WORD-1] ^ sub;
    ea_raw = a_number[SIZE_WORD-2 -: SIZE_EXPONENT];
    eb_raw = b_number[SIZE_WORD-2 -: SIZE_EXPONENT];
    hid_a  = |ea_raw;
    hid_b  = |eb_raw;
    ea_eff = hid_a ? ea_raw : EXP_ONE;
    eb_eff = hid_b ? eb_raw : EXP_ONE;
    ma     = {hid_a, a_number[FW-1:0]};
    mb     = {hid_b, b_number[FW-1:0]};
    // Equal magnitudes keep A on top, so the sign follows A.
    swap   = (ea_eff < eb_eff) || ((ea_eff == eb_eff) && (ma < mb));
    el     = swap ? eb_eff : ea_eff;
    es     = swap ? ea_eff : eb_eff;
    ml     = swap ? mb : ma;
    ms     = swap ? ma : mb;
    sign_l = swap ? sb_eff : sa;
  end

  logic                     s1_valid, s1_eff_op, s1_sign;
  logic [SIZE_MANTISSA-1:0] s1_ml, s1_ms;
  logic [SIZE_EXPONENT-1:0] s1_el, s1_es, s1_d;

  // Stage-1 register: ordered operands and exponent difference.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_eff_op <= 1'b0;
      s1_sign   <= 1'b0;
      s1_ml     <= '0;
      s1_ms     <= '0;
      s1_el     <= '0;
      s1_es     <= '0;
      s1_d      <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_eff_op <= sa ^ sb_eff;
      s1_sign   <= sign_l;
      s1_ml     <= ml;
      s1_ms     <= ms;
      s1_el     <= el;
      s1_es     <= es;
      s1_d      <= el - es;
    end
  end

`ifdef SPECIAL_CASE_EN
  localparam logic [SIZE_WORD-1:0] QNAN =
    {1'b0, {SIZE_EXPONENT{1'b1}}, 1'b1, {(FW-1){1'b0}}};
  logic                 a_all, b_all, a_nan, b_nan, spc;
  logic [SIZE_WORD-1:0] spc_res;
  logic                 s1_spc;
  logic [SIZE_WORD-1:0] s1_spc_res;

  // Inf/NaN detection and the IEEE result for those operands.
  always_comb begin
    a_all   = &ea_raw;
    b_all   = &eb_raw;
    a_nan   = a_all & (|a_number[FW-1:0]);
    b_nan   = b_all & (|b_number[FW-1:0]);
    spc     = a_all | b_all;
    spc_res = '0;
    if (a_nan || b_nan)
      spc_res = QNAN;
    else if (a_all && b_all)
      spc_res = (sa ^ sb_eff) ? QNAN : {sa, {SIZE_EXPONENT{1'b1}}, {FW{1'b0}}};
    else if (a_all)
      spc_res = {sa, {SIZE_EXPONENT{1'b1}}, {FW{1'b0}}};
    else if (b_all)
      spc_res = {sb_eff, {SIZE_EXPONENT{1'b1}}, {FW{1'b0}}};
  end

  // Stage-1 register for the special-case flag and result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_spc     <= 1'b0;
      s1_spc_res <= '0;
    end else if (en) begin
      s1_spc     <= spc;
      s1_spc_res <= spc_res;
    end
  end
`endif

  // ---------------- Stage 2: alignment shift with sticky ---------------------
  logic [SIZE_COUNTER-1:0] shift_amt;
  logic [2*MW-1:0]         wide;
  logic                    sticky, all_out;
  logic [MW-1:0]           mb_al;

  // Shift the smaller significand right; bits falling off collapse into S.
  always_comb begin
    all_out   = (s1_d >= ALL_OUT);
    shift_amt = (s1_d > MAX_SHIFT) ? SIZE_COUNTER'(SIZE_MANTISSA + 2)
                                   : s1_d[SIZE_COUNTER-1:0];
    wide      = {s1_ms, 3'b000, {MW{1'b0}}} >> shift_amt;
    sticky    = wide[MW] | (|wide[MW-1:0]);
    mb_al     = all_out ? {{(MW-1){1'b0}}, |s1_ms}
                        : {wide[2*MW-1:MW+1], sticky};
  end

  // Stage-2 register: drives the outputs and holds them under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      eff_op     <= 1'b0;
      near_path  <= 1'b0;
      sign_o     <= 1'b0;
      m_a_number <= '0;
      m_b_number <= '0;
      e_a_number <= '0;
      e_b_number <= '0;
    end else if (en) begin
      out_valid  <= s1_valid;
      eff_op     <= s1_eff_op;
      near_path  <= s1_eff_op & (s1_d <= EXP_ONE);
      sign_o     <= s1_sign;
      m_a_number <= {s1_ml, 3'b000};
      m_b_number <= mb_al;
      e_a_number <= s1_el;
      e_b_number <= s1_es;
    end
  end

`ifdef SPECIAL_CASE_EN
  // Stage-2 register for the special-case outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      special_o     <= 1'b0;
      special_res_o <= '0;
    end else if (en) begin
      special_o     <= s1_spc;
      special_res_o <= s1_spc_res;
    end
  end
`endif

endmodule
